// File: rtl/sync_fifo_pkg.sv
// Shared FIFO constants: read-mode encodings and default word/address geometry.
package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  localparam int FIFO_DATASIZE  = 12;
  localparam int FIFO_ADDRSIZE  = 8;
endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
);
  logic                write_enable;
  logic [DATASIZE-1:0] write_data;
  logic                read_enable;
  logic                flush;
  logic [DATASIZE-1:0] read_data;
  logic                read_valid;
  logic                write_full;
  logic                read_empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   fill_count;
  logic                overflow;
  logic                underflow;

  modport master (
    output write_enable, write_data, read_enable, flush,
    input  read_data, read_valid, write_full, read_empty, almost_full,
           almost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data, read_enable, flush,
    output read_data, read_valid, write_full, read_empty, almost_full,
           almost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_fifomem.sv
// FIFO storage array: clocked write gated by the full flag, combinational read.
module fifomem
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                wclk,
  input  logic                wclken,
  input  logic                wfull,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] wdata,
  output logic [DATASIZE-1:0] rdata
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  always_ff @(posedge wclk) begin
    if (wclken && !wfull) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, status/sticky flags and the
// read-side output stage (registered or first-word-fall-through).
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATASIZE      = FIFO_DATASIZE,
  parameter int ADDRSIZE      = FIFO_ADDRSIZE,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] FULL_COUNT   = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_LEVEL  = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEMPTY_LEVEL = (ADDRSIZE+1)'(AEMPTY_THRESH);

  generate
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("sync_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo: FWFT must be FIFO_MODE_STD or FIFO_MODE_FWFT");
    end
  endgenerate

  logic [ADDRSIZE-1:0] wptr;
  logic [ADDRSIZE-1:0] rptr;
  logic [ADDRSIZE:0]   count;
  logic                overflow_q;
  logic                underflow_q;
  logic                write_full;
  logic                read_empty;
  logic                write_accept;
  logic                read_accept;
  logic                mem_wclken;
  logic [DATASIZE-1:0] mem_rdata;

  assign write_full   = (count == FULL_COUNT);
  assign read_empty   = (count == '0);
  assign write_accept = bus.write_enable && !write_full && !bus.flush;
  assign read_accept  = bus.read_enable && !read_empty && !bus.flush;
  // Flush must not disturb memory, so it blocks the write strobe as well.
  assign mem_wclken   = bus.write_enable && !bus.flush;

  fifomem #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE)) u_fifomem (
    .wclk   (clk),
    .wclken (mem_wclken),
    .wfull  (write_full),
    .waddr  (wptr),
    .raddr  (rptr),
    .wdata  (bus.write_data),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write_accept) wptr <= wptr + 1'b1;
      if (read_accept)  rptr <= rptr + 1'b1;
      case ({write_accept, read_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.write_enable && write_full) overflow_q  <= 1'b1;
      if (bus.read_enable && read_empty)  underflow_q <= 1'b1;
    end
  end

  assign bus.write_full   = write_full;
  assign bus.read_empty   = read_empty;
  assign bus.almost_full  = (count >= AFULL_LEVEL);
  assign bus.almost_empty = (count <= AEMPTY_LEVEL);
  assign bus.fill_count   = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.read_data  = mem_rdata;
      assign bus.read_valid = !read_empty;
    end else begin : g_std
      logic [DATASIZE-1:0] rdata_q;
      logic                rvalid_q;

      // read_accept is already low during flush, so valid clears while data holds.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= read_accept;
          if (read_accept) rdata_q <= mem_rdata;
        end
      end

      assign bus.read_data  = rdata_q;
      assign bus.read_valid = rvalid_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a registered-read and a FWFT instance share stimulus;
// directed scenarios plus a randomized run against a queue reference model.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DW = 12;
  localparam int AW = 2;

  logic clk;
  logic reset_n;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) s_if ();
  sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) f_if ();

  sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(FIFO_MODE_STD),
              .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_std (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (s_if.slave)
  );

  sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(FIFO_MODE_FWFT),
              .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_fwft (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (f_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one cycle of inputs to both instances, returns at the next negedge idle.
  task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
    s_if.write_enable = we; s_if.write_data = wd; s_if.read_enable = re; s_if.flush = fl;
    f_if.write_enable = we; f_if.write_data = wd; f_if.read_enable = re; f_if.flush = fl;
    @(posedge clk);
    @(negedge clk);
    s_if.write_enable = 1'b0; s_if.read_enable = 1'b0; s_if.flush = 1'b0;
    f_if.write_enable = 1'b0; f_if.read_enable = 1'b0; f_if.flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    act.push_back(32'(s_if.fill_count));   exp.push_back(0); nm.push_back("rst_fill");
    act.push_back(32'(s_if.read_empty));   exp.push_back(1); nm.push_back("rst_empty");
    act.push_back(32'(s_if.write_full));   exp.push_back(0); nm.push_back("rst_full");
    act.push_back(32'(s_if.almost_empty)); exp.push_back(1); nm.push_back("rst_aempty");
    act.push_back(32'(s_if.almost_full));  exp.push_back(0); nm.push_back("rst_afull");
    act.push_back(32'(s_if.overflow));     exp.push_back(0); nm.push_back("rst_ovf");
    act.push_back(32'(s_if.underflow));    exp.push_back(0); nm.push_back("rst_unf");
    act.push_back(32'(s_if.read_valid));   exp.push_back(0); nm.push_back("rst_std_valid");
    act.push_back(32'(s_if.read_data));    exp.push_back(0); nm.push_back("rst_std_data");
    act.push_back(32'(f_if.read_valid));   exp.push_back(0); nm.push_back("rst_fwft_valid");
    act.push_back(32'(f_if.read_empty));   exp.push_back(1); nm.push_back("rst_fwft_empty");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill_overflow();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 2) begin
        act.push_back(32'(s_if.almost_full)); exp.push_back(0); nm.push_back("afull_after_2");
      end
      if (i == 3) begin
        act.push_back(32'(s_if.almost_full)); exp.push_back(1); nm.push_back("afull_after_3");
        act.push_back(32'(s_if.fill_count));  exp.push_back(3); nm.push_back("fill_after_3");
      end
      if (i == 4) begin
        act.push_back(32'(s_if.write_full)); exp.push_back(1); nm.push_back("full_after_4");
        act.push_back(32'(s_if.overflow));   exp.push_back(0); nm.push_back("ovf_after_4");
      end
    end
    act.push_back(32'(s_if.write_full)); exp.push_back(1); nm.push_back("full_after_5");
    act.push_back(32'(s_if.fill_count)); exp.push_back(4); nm.push_back("fill_after_5");
    act.push_back(32'(s_if.overflow));   exp.push_back(1); nm.push_back("ovf_after_5");
    act.push_back(32'(f_if.overflow));   exp.push_back(1); nm.push_back("fwft_ovf_after_5");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_drain_underflow();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    for (int i = 1; i <= 4; i++) begin
      act.push_back(32'(f_if.read_data));  exp.push_back(32'(i)); nm.push_back($sformatf("fwft_head_%0d", i));
      drive(1'b0, '0, 1'b1, 1'b0);
      act.push_back(32'(s_if.read_valid)); exp.push_back(1);      nm.push_back($sformatf("std_valid_%0d", i));
      act.push_back(32'(s_if.read_data));  exp.push_back(32'(i)); nm.push_back($sformatf("std_data_%0d", i));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    act.push_back(32'(s_if.read_valid)); exp.push_back(0);     nm.push_back("std_valid_idle");
    act.push_back(32'(s_if.read_data));  exp.push_back(32'h4); nm.push_back("std_data_hold");
    act.push_back(32'(s_if.underflow));  exp.push_back(0);     nm.push_back("unf_before_5th");
    drive(1'b0, '0, 1'b1, 1'b0);
    act.push_back(32'(s_if.underflow));  exp.push_back(1);     nm.push_back("unf_after_5th");
    act.push_back(32'(s_if.read_empty)); exp.push_back(1);     nm.push_back("empty_after_5th");
    act.push_back(32'(s_if.read_valid)); exp.push_back(0);     nm.push_back("std_valid_5th");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) drive(1'b1, DW'(12'h010 + i), 1'b0, 1'b0);
    drive(1'b1, 12'h020, 1'b1, 1'b0);
    act.push_back(32'(s_if.fill_count)); exp.push_back(3);      nm.push_back("both_full_fill");
    act.push_back(32'(s_if.write_full)); exp.push_back(0);      nm.push_back("both_full_flag");
    act.push_back(32'(s_if.read_data));  exp.push_back(32'h11); nm.push_back("both_full_rdata");
    act.push_back(32'(s_if.overflow));   exp.push_back(1);      nm.push_back("both_full_ovf");
    drive(1'b1, 12'h021, 1'b1, 1'b0);
    act.push_back(32'(s_if.fill_count)); exp.push_back(3);      nm.push_back("both_mid_fill");
    act.push_back(32'(s_if.read_data));  exp.push_back(32'h12); nm.push_back("both_mid_rdata");
    act.push_back(32'(f_if.read_data));  exp.push_back(32'h13); nm.push_back("both_mid_fwft_head");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_fwft_first();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    drive(1'b0, '0, 1'b0, 1'b1);
    act.push_back(32'(f_if.read_valid)); exp.push_back(0);       nm.push_back("fwft_valid_empty");
    drive(1'b1, 12'hABC, 1'b0, 1'b0);
    act.push_back(32'(f_if.read_data));  exp.push_back(32'hABC); nm.push_back("fwft_first_data");
    act.push_back(32'(f_if.read_valid)); exp.push_back(1);       nm.push_back("fwft_first_valid");
    drive(1'b0, '0, 1'b1, 1'b0);
    act.push_back(32'(f_if.read_empty)); exp.push_back(1);       nm.push_back("fwft_pop_empty");
    act.push_back(32'(f_if.read_valid)); exp.push_back(0);       nm.push_back("fwft_pop_valid");
    act.push_back(32'(s_if.read_data));  exp.push_back(32'hABC); nm.push_back("std_pop_data");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0]   act[$];
    logic [31:0]   exp[$];
    string         nm[$];
    logic [DW-1:0] d;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      d = DW'(12'h100 + k * 12'h011);
      drive(1'b1, d, 1'b0, 1'b0);
      act.push_back(32'(f_if.read_data));  exp.push_back(32'(d)); nm.push_back($sformatf("wrap_fwft_%0d", k));
      drive(1'b0, '0, 1'b1, 1'b0);
      act.push_back(32'(s_if.read_data));  exp.push_back(32'(d)); nm.push_back($sformatf("wrap_std_%0d", k));
      act.push_back(32'(s_if.fill_count)); exp.push_back(0);      nm.push_back($sformatf("wrap_fill_%0d", k));
    end
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(12'h030 + i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    act.push_back(32'(s_if.fill_count)); exp.push_back(3);      nm.push_back("pre_flush_fill");
    act.push_back(32'(s_if.overflow));   exp.push_back(1);      nm.push_back("pre_flush_ovf");
    drive(1'b1, 12'h036, 1'b0, 1'b1);
    act.push_back(32'(s_if.fill_count)); exp.push_back(0);      nm.push_back("flush_fill");
    act.push_back(32'(s_if.read_empty)); exp.push_back(1);      nm.push_back("flush_empty");
    act.push_back(32'(s_if.overflow));   exp.push_back(0);      nm.push_back("flush_ovf");
    act.push_back(32'(s_if.read_data));  exp.push_back(32'h31); nm.push_back("flush_std_data_hold");
    act.push_back(32'(f_if.fill_count)); exp.push_back(0);      nm.push_back("flush_fwft_fill");
    drive(1'b1, 12'h037, 1'b0, 1'b0);
    act.push_back(32'(f_if.read_data));  exp.push_back(32'h37); nm.push_back("post_flush_head");
    act.push_back(32'(s_if.fill_count)); exp.push_back(1);      nm.push_back("post_flush_fill");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] act[$];
    logic [31:0] exp[$];
    string       nm[$];
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(12'h040 + i), 1'b0, 1'b0);
    drive(1'b1, 12'h046, 1'b1, 1'b0);
    act.push_back(32'(s_if.read_valid)); exp.push_back(1);      nm.push_back("mid_std_valid");
    act.push_back(32'(s_if.read_data));  exp.push_back(32'h41); nm.push_back("mid_std_data");
    #2 reset_n = 1'b0;
    #1;
    act.push_back(32'(s_if.fill_count));   exp.push_back(0); nm.push_back("async_fill");
    act.push_back(32'(s_if.read_empty));   exp.push_back(1); nm.push_back("async_empty");
    act.push_back(32'(s_if.write_full));   exp.push_back(0); nm.push_back("async_full");
    act.push_back(32'(s_if.almost_empty)); exp.push_back(1); nm.push_back("async_aempty");
    act.push_back(32'(s_if.almost_full));  exp.push_back(0); nm.push_back("async_afull");
    act.push_back(32'(s_if.overflow));     exp.push_back(0); nm.push_back("async_ovf");
    act.push_back(32'(s_if.underflow));    exp.push_back(0); nm.push_back("async_unf");
    act.push_back(32'(s_if.read_valid));   exp.push_back(0); nm.push_back("async_std_valid");
    act.push_back(32'(s_if.read_data));    exp.push_back(0); nm.push_back("async_std_data");
    act.push_back(32'(f_if.read_valid));   exp.push_back(0); nm.push_back("async_fwft_valid");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    act.push_back(32'(s_if.underflow));  exp.push_back(1); nm.push_back("post_rst_unf");
    act.push_back(32'(s_if.read_valid)); exp.push_back(0); nm.push_back("post_rst_valid");
    foreach (act[i]) begin
      n_compared++;
      if (act[i] !== exp[i]) begin
        n_mismatched++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
    logic [DW-1:0] m_data = '0;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      logic          we, re, fl;
      bit            wacc, racc;
      logic [DW-1:0] wd;
      int            cnt;
      logic [31:0]   act[14];
      logic [31:0]   exp[14];
      bit            chk[14];
      string         nm[14];
      we = ($urandom_range(0, 3) < ((c < 200) ? 3 : 1));
      re = ($urandom_range(0, 3) < ((c < 200) ? 1 : 3));
      fl = ($urandom_range(0, 39) == 0);
      wd = DW'($urandom);
      if (fl) begin
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0;
      end else begin
        wacc = we && (q.size() < 4);
        racc = re && (q.size() > 0);
        if (we && q.size() == 4) m_ovf = 1'b1;
        if (re && q.size() == 0) m_unf = 1'b1;
        m_vld = racc;
        if (racc) m_data = q.pop_front();
        if (wacc) q.push_back(wd);
      end
      drive(we, wd, re, fl);
      cnt = q.size();
      act[0]  = 32'(s_if.fill_count);   exp[0]  = 32'(cnt);         nm[0]  = "rnd_fill";
      act[1]  = 32'(s_if.write_full);   exp[1]  = 32'(cnt == 4);    nm[1]  = "rnd_full";
      act[2]  = 32'(s_if.read_empty);   exp[2]  = 32'(cnt == 0);    nm[2]  = "rnd_empty";
      act[3]  = 32'(s_if.almost_full);  exp[3]  = 32'(cnt >= 3);    nm[3]  = "rnd_afull";
      act[4]  = 32'(s_if.almost_empty); exp[4]  = 32'(cnt <= 1);    nm[4]  = "rnd_aempty";
      act[5]  = 32'(s_if.overflow);     exp[5]  = 32'(m_ovf);       nm[5]  = "rnd_ovf";
      act[6]  = 32'(s_if.underflow);    exp[6]  = 32'(m_unf);       nm[6]  = "rnd_unf";
      act[7]  = 32'(s_if.read_valid);   exp[7]  = 32'(m_vld);       nm[7]  = "rnd_std_valid";
      act[8]  = 32'(s_if.read_data);    exp[8]  = 32'(m_data);      nm[8]  = "rnd_std_data";
      act[9]  = 32'(f_if.fill_count);   exp[9]  = 32'(cnt);         nm[9]  = "rnd_fwft_fill";
      act[10] = 32'(f_if.read_valid);   exp[10] = 32'(cnt != 0);    nm[10] = "rnd_fwft_valid";
      act[11] = 32'(f_if.read_data);    exp[11] = (cnt != 0) ? 32'(q[0]) : 32'h0; nm[11] = "rnd_fwft_data";
      act[12] = 32'(f_if.overflow);     exp[12] = 32'(m_ovf);       nm[12] = "rnd_fwft_ovf";
      act[13] = 32'(f_if.underflow);    exp[13] = 32'(m_unf);       nm[13] = "rnd_fwft_unf";
      foreach (chk[i]) chk[i] = 1'b1;
      chk[11] = (cnt != 0);
      for (int i = 0; i < 14; i++) begin
        if (chk[i]) begin
          n_compared++;
          if (act[i] !== exp[i]) begin
            n_mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", nm[i], c, act[i], exp[i]);
          end
        end
      end
    end
  endtask

  initial begin
    s_if.write_enable = 1'b0; s_if.write_data = '0; s_if.read_enable = 1'b0; s_if.flush = 1'b0;
    f_if.write_enable = 1'b0; f_if.write_data = '0; f_if.read_enable = 1'b0; f_if.flush = 1'b0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_fwft_first();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 12, word width in bits.
REQ-002 Parameter ADDRSIZE, default 8, address bits; DEPTH = 1<<ADDRSIZE.
REQ-003 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 Parameter AFULL_THRESH, default DEPTH-4, almost_full level; legal range 1..DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 4, almost_empty level; legal range 0..DEPTH-1.
REQ-006 clk  input  1  single clock for all state; one clock, reset is asynchronous and active-low.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 write_enable  input  1  write request.
REQ-009 write_data  input  DATASIZE  write word.
REQ-010 read_enable  input  1  read request; in FWFT mode, pop of the presented word.
REQ-011 flush  input  1  synchronous clear of FIFO state.
REQ-012 read_data  output  DATASIZE  read word.
REQ-013 read_valid  output  1  read_data qualifier.
REQ-014 write_full, read_empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 fill_count  output  ADDRSIZE+1  stored word count, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted iff write_enable && !write_full; stores at wptr and increments wptr, wrapping at DEPTH.
REQ-018 Read accepted iff read_enable && !read_empty; increments rptr, wrapping at DEPTH.
REQ-019 fill_count updates on the edge following the access: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-020 write_full = (fill_count == DEPTH); read_empty = (fill_count == 0); both are derived only from the registered count.
REQ-021 When full, a write concurrent with a read is rejected; when empty, a read concurrent with a write is rejected.
REQ-022 almost_full = (fill_count >= AFULL_THRESH); almost_empty = (fill_count <= AEMPTY_THRESH).
REQ-023 FWFT=0: on an accepted read, read_data is registered from mem[rptr] and read_valid is high for exactly the next cycle.
REQ-024 FWFT=0: read_data holds its last value when no read is accepted.
REQ-025 FWFT=1: read_data = mem[rptr] combinationally, and read_valid = !read_empty.
REQ-026 FWFT=1: the first word written into an empty FIFO appears on read_data with read_valid high one cycle after the write edge.
REQ-027 overflow sets on write_enable && write_full; underflow sets on read_enable && read_empty; both stay set until flush or reset.
REQ-028 flush, one cycle, clears wptr, rptr, fill_count, overflow, underflow and read_valid.
REQ-029 flush overrides concurrent reads and writes; neither is accepted.
REQ-030 flush leaves memory contents unchanged, and in FWFT=0 it leaves read_data unchanged.
REQ-031 Illegal threshold parameters are flagged by an elaboration-time check.

Reset
REQ-032 On reset_n low, asynchronously: wptr = rptr = 0, fill_count = 0, read_empty = 1, write_full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0, read_valid = 0; read_data = 0 in FWFT=0.
REQ-033 Reset deassertion takes effect at the first clk edge with reset_n high.
REQ-034 Reset asserted mid-transfer discards all stored words, with no partial update.

Structure
REQ-035 Shared package fifo_pkg holds FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1, and the default DATASIZE and ADDRSIZE.
REQ-036 Storage is the existing fifomem sub-module: write clock = clk, write_full gating the write, combinational read.
REQ-037 Pointer, count, flag and output-register logic stay in sync_fifo; no other sub-module.

Verification (DATASIZE=12, ADDRSIZE=2, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-038 FWFT=0: write 0x001..0x004, then a 5th write 0x005 -> write_full=1, fill_count=4, almost_full=1 after the third write, overflow=1, 0x005 not stored.
REQ-039 FWFT=0: read 4 words -> read_data 0x001..0x004, each with read_valid one cycle after its read; a 5th read sets underflow=1 and read_empty=1.
REQ-040 Full FIFO, write_enable and read_enable together -> read accepted, write rejected, fill_count=3; then both again on a non-full FIFO -> fill_count stays 3.
REQ-041 FWFT=1: one write of 0xABC into an empty FIFO -> next cycle read_data=0xABC, read_valid=1; read_enable -> read_empty=1, read_valid=0.
REQ-042 Six write/read pairs through the wrap boundary -> data order preserved; after every pair the pointers are equal and fill_count=0.
REQ-043 Three words stored with overflow set; flush asserted together with write_enable -> fill_count=0, read_empty=1, overflow=0, no write accepted; reset_n pulsed low mid-stream -> all REQ-032 values observed immediately, without a clk edge.
